// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: in-order writeback (A) vs queued mul/div results (B).
// A wins unless B has starved; younger A writes squash queued B writes to the same rd.
package combined_wire;

  typedef logic [63:0] word_t;

  typedef struct packed {
    logic [4:0] reg_dest_addr;
    logic       reg_write_enable;
    word_t      data;
  } reg_writer;

endpackage

module wb_port_arbiter
  import combined_wire::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [69:0] a_wr,
  output logic        stall_a,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [69:0] b_wr,
  input  logic [4:0]  q_addr0,
  input  logic [4:0]  q_addr1,
  output logic        q_busy0,
  output logic        q_busy1,
  output logic [69:0] rf_wr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  reg_writer a_in;
  reg_writer b_in;
  reg_writer rf_q;

  logic [4:0] f_rd   [FIFO_DEPTH];
  word_t      f_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] f_vld;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] starve;

  logic empty;
  logic full;
  logic any_v;
  logic head_v;
  logic starved;
  logic a_real;
  logic a_gnt;
  logic b_gnt;
  logic push;
  logic pop;

  assign a_in  = a_wr;
  assign b_in  = b_wr;
  assign rf_wr = rf_q;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign any_v   = |f_vld;
  assign head_v  = f_vld[rd_ptr];
  assign starved = (starve == CW'(STARVE_LIMIT));
  assign a_real  = a_in.reg_write_enable &&
                   (a_in.reg_dest_addr != 5'd0);

  assign b_ready = !full;
  assign push    = b_valid && !full &&
                   b_in.reg_write_enable &&
                   (b_in.reg_dest_addr != 5'd0);

  // Grant decision: forced B slot when starved, else A, else B head.
  always_comb begin
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    stall_a = any_v && starved;
    unique case (1'b1)
      stall_a:           b_gnt = head_v;
      a_real && !stall_a: a_gnt = 1'b1;
      default:           b_gnt = head_v;
    endcase
  end

  // Head leaves when written or when it was squashed.
  assign pop = !empty && (b_gnt || !head_v);

  // Busy lookup over live entries; x0 is never busy.
  always_comb begin
    q_busy0 = 1'b0;
    q_busy1 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (f_vld[i] && f_rd[i] == q_addr0) q_busy0 = 1'b1;
      if (f_vld[i] && f_rd[i] == q_addr1) q_busy1 = 1'b1;
    end
    if (q_addr0 == 5'd0) q_busy0 = 1'b0;
    if (q_addr1 == 5'd0) q_busy1 = 1'b0;
  end

  // B queue: squash on A grant, then pop, then push the younger entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_vld  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        f_rd[i]   <= '0;
        f_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (a_gnt && f_rd[i] == a_in.reg_dest_addr)
          f_vld[i] <= 1'b0;
      end
      if (pop) begin
        f_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        f_rd[wr_ptr]   <= b_in.reg_dest_addr;
        f_data[wr_ptr] <= b_in.data;
        f_vld[wr_ptr]  <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Starvation counter: A wins while B waits; cleared on B grant or no live entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve <= '0;
    end else if (b_gnt || !any_v) begin
      starve <= '0;
    end else if (a_gnt && !starved) begin
      starve <= starve + 1'b1;
    end
  end

  // Registered regfile write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_q <= '0;
    end else if (a_gnt) begin
      rf_q <= a_in;
    end else if (b_gnt) begin
      rf_q <= '{f_rd[rd_ptr], 1'b1, f_data[rd_ptr]};
    end else begin
      rf_q <= '0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [69:0] a_wr = '0;
  logic        stall_a;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [69:0] b_wr = '0;
  logic [4:0]  q_addr0 = '0;
  logic [4:0]  q_addr1 = '0;
  logic        q_busy0;
  logic        q_busy1;
  logic [69:0] rf_wr;

  wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .a_wr(a_wr), .stall_a(stall_a),
    .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr),
    .q_addr0(q_addr0), .q_addr1(q_addr1),
    .q_busy0(q_busy0), .q_busy1(q_busy1), .rf_wr(rf_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
    bit          v;
  } ent_t;

  ent_t mq[$];
  int   starve = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   last_stall = 0;
  bit   last_ready = 1;

  task automatic chk(string tag, logic [69:0] got, logic [69:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [69:0] mk(logic [4:0] rd, logic en, logic [63:0] d);
    return {rd, en, d};
  endfunction

  // One clock: check combinational outputs, then registered write.
  task automatic step();
    bit anyv, stl, rdy, ag, bg, pop, push, b0, b1;
    logic [69:0] erf, a_s, b_s;
    #2;
    anyv = 0; b0 = 0; b1 = 0;
    foreach (mq[i]) begin
      if (mq[i].v) begin
        anyv = 1;
        if (mq[i].rd == q_addr0 && q_addr0 != 0) b0 = 1;
        if (mq[i].rd == q_addr1 && q_addr1 != 0) b1 = 1;
      end
    end
    stl = anyv && (starve == LIM);
    rdy = (mq.size() < DEPTH);
    chk("stall_a", 70'(stall_a), 70'(stl));
    chk("b_ready", 70'(b_ready), 70'(rdy));
    chk("q_busy0", 70'(q_busy0), 70'(b0));
    chk("q_busy1", 70'(q_busy1), 70'(b1));
    a_s = a_wr;
    b_s = b_wr;
    ag = 0; bg = 0;
    if (stl) bg = mq[0].v;
    else if (a_s[64] && a_s[69:65] != 0) ag = 1;
    else if (mq.size() > 0) bg = mq[0].v;
    if (ag) erf = a_s;
    else if (bg) erf = mk(mq[0].rd, 1'b1, mq[0].d);
    else erf = '0;
    pop  = (mq.size() > 0) && (bg || !mq[0].v);
    push = b_valid && rdy && b_s[64] && (b_s[69:65] != 0);
    @(posedge clk);
    #1;
    chk("rf_wr", rf_wr, erf);
    last_stall = stl;
    last_ready = rdy;
    if (bg || !anyv) starve = 0;
    else if (ag && starve < LIM) starve++;
    if (ag) foreach (mq[i]) if (mq[i].rd == a_s[69:65]) mq[i].v = 0;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{b_s[69:65], b_s[63:0], 1'b1});
  endtask

  task automatic idle(int n);
    a_wr = '0;
    b_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    logic [63:0] d5;
    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf", rf_wr, '0);
    chk("rst_bready", 70'(b_ready), 70'(1));
    chk("rst_stall", 70'(stall_a), 70'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    chk("idle_en", 70'(rf_wr[64]), 70'(0));

    // A write with B idle
    a_wr = mk(5'd5, 1'b1, 64'h11);
    step();
    chk("a_x5", rf_wr, mk(5'd5, 1'b1, 64'h11));
    idle(1);

    // Starvation: B x7 queued, A writes x1.. every cycle
    b_valid = 1'b1;
    b_wr = mk(5'd7, 1'b1, 64'hAA);
    step();
    b_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      a_wr = mk(5'(k), 1'b1, 64'(k * 16));
      step();
      chk("starve_a", rf_wr, mk(5'(k), 1'b1, 64'(k * 16)));
    end
    d5 = 64'h50;
    a_wr = mk(5'd5, 1'b1, d5);
    step();
    chk("starve_b", rf_wr, mk(5'd7, 1'b1, 64'hAA));
    step();
    chk("starve_a5", rf_wr, mk(5'd5, 1'b1, d5));
    idle(2);

    // Fill FIFO while A busy
    a_wr = mk(5'd1, 1'b1, 64'h1);
    b_valid = 1'b1;
    b_wr = mk(5'd8, 1'b1, 64'h8);
    step();
    b_wr = mk(5'd9, 1'b1, 64'h9);
    step();
    q_addr0 = 5'd8;
    #1;
    chk("full_bready", 70'(b_ready), 70'(0));
    chk("busy_x8", 70'(q_busy0), 70'(1));
    b_wr = mk(5'd11, 1'b1, 64'hB);
    a_wr = mk(5'd2, 1'b1, 64'h2);
    repeat (3) begin
      step();
      if (last_ready) b_valid = 1'b0;
    end
    idle(6);

    // WAW squash
    a_wr = mk(5'd3, 1'b1, 64'h3);
    b_valid = 1'b1;
    b_wr = mk(5'd10, 1'b1, 64'h1);
    step();
    b_valid = 1'b0;
    a_wr = mk(5'd10, 1'b1, 64'h2);
    q_addr1 = 5'd10;
    step();
    chk("waw_a", rf_wr, mk(5'd10, 1'b1, 64'h2));
    a_wr = '0;
    step();
    chk("waw_drop", 70'(rf_wr[64]), 70'(0));
    chk("waw_busy", 70'(q_busy1), 70'(0));
    idle(1);

    // B write to x0
    b_valid = 1'b1;
    b_wr = mk(5'd0, 1'b1, 64'hDEAD);
    step();
    b_valid = 1'b0;
    step();
    chk("x0_drop", 70'(rf_wr[64]), 70'(0));

    // Reset with entries queued
    a_wr = mk(5'd1, 1'b1, 64'h1);
    b_valid = 1'b1;
    b_wr = mk(5'd12, 1'b1, 64'hC);
    step();
    b_wr = mk(5'd13, 1'b1, 64'hD);
    step();
    b_valid = 1'b0;
    q_addr0 = 5'd12;
    q_addr1 = 5'd13;
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_rf", rf_wr, '0);
    chk("mrst_bready", 70'(b_ready), 70'(1));
    chk("mrst_stall", 70'(stall_a), 70'(0));
    chk("mrst_busy0", 70'(q_busy0), 70'(0));
    chk("mrst_busy1", 70'(q_busy1), 70'(0));
    mq.delete();
    starve = 0;
    last_stall = 0;
    last_ready = 1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(4);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) begin
        a_wr = ($urandom_range(0, 2) != 0) ?
               mk(5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0),
                  {$urandom, $urandom}) : '0;
      end
      if (!(b_valid && !last_ready)) begin
        b_valid = 1'($urandom_range(0, 1));
        b_wr = mk(5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 5) != 0),
                  {$urandom, $urandom});
      end
      q_addr0 = 5'($urandom_range(0, 7));
      q_addr1 = 5'($urandom_range(0, 7));
      step();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
